// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the Simple RISC Machine.
// Owns PC/IR, reads over a wait-state bus, hands words off via valid/ready.
module fetch_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_cmd,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              fetch_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WLAST = CW'(MAX_WAIT - 1);
  localparam logic [2:0] CMD_NONE = 3'b001;
  localparam logic [2:0] CMD_READ = 3'b010;

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_HALT,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d   = redirect_pc;
          wcnt_d = '0;
        end else if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          wcnt_d  = '0;
          state_d = S_HOLD;
        end else if (wcnt_q == WLAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        // a redirect drops the held word even if it is being accepted
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (instr_ready) begin
          state_d = halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!halt) begin
          state_d = S_FETCH;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  assign mem_cmd     = (state_q == S_FETCH) ? CMD_READ : CMD_NONE;
  assign mem_addr    = (state_q == S_FETCH) ? pc_q : '0;
  assign instr_valid = (state_q == S_HOLD);
  assign ir_out      = ir_q;
  assign pc_out      = pc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic for fetch_unit,
// compared every cycle against a transaction-level model.
module tb_fetch_unit;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_cmd;
  logic [15:0] ir_out;
  logic [8:0]  pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        halt = 1'b0;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .DATA_W(16), .ADDR_W(9), .RESET_PC(9'd0), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_cmd(mem_cmd),
    .ir_out(ir_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // model: word held for controller, halted, dead after timeout
  int m_pc, m_ir, m_waits;
  bit m_holding, m_halted, m_dead, m_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_waits = 0;
    m_holding = 0; m_halted = 0; m_dead = 0; m_err = 0;
  endtask

  task automatic compare_all();
    bit reading;
    reading = !m_dead && !m_holding && !m_halted;
    chk("mem_cmd", 32'(mem_cmd), reading ? 32'd2 : 32'd1);
    chk("mem_addr", 32'(mem_addr), reading ? 32'(m_pc) : 32'd0);
    chk("ir_out", 32'(ir_out), 32'(m_ir));
    chk("pc_out", 32'(pc_out), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_holding));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  task automatic tick(input bit rdy, input logic [15:0] rd, input bit irdy,
                      input bit red, input logic [8:0] rpc, input bit hlt);
    mem_ready = rdy; mem_rdata = rd; instr_ready = irdy;
    redirect = red; redirect_pc = rpc; halt = hlt;
    if (m_dead) begin
    end else if (m_holding) begin
      if (red) begin m_pc = int'(rpc); m_holding = 0; end
      else if (irdy) begin m_holding = 0; m_halted = hlt; end
    end else if (m_halted) begin
      if (red) begin m_pc = int'(rpc); m_halted = 0; end
      else if (!hlt) m_halted = 0;
    end else begin
      if (red) begin
        m_pc = int'(rpc); m_waits = 0;
      end else if (rdy) begin
        m_ir = int'(rd); m_pc = (m_pc + 1) % 512;
        m_waits = 0; m_holding = 1;
      end else begin
        m_waits++;
        if (m_waits == MW) begin m_dead = 1; m_err = 1; end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy, input bit irdy, input bit hlt);
    for (int i = 0; i < n; i++) tick(rdy, 16'h0, irdy, 1'b0, 9'h0, hlt);
  endtask

  // asserted mid-cycle so the asynchronous path is observed before an edge
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    compare_all();
  endtask

  initial begin
    int rp, lp;
    model_reset();
    #1;
    do_reset();
    chk("t1_cmd0", 32'(mem_cmd), 32'd2);

    // 1: zero-wait stream, one word per two cycles
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", 32'(mem_addr), 32'(i));
      tick(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0, 9'h0, 1'b0);
      chk("t1_ir", 32'(ir_out), 32'h1000 + 32'(i));
      chk("t1_valid", 32'(instr_valid), 32'd1);
      tick(1'b0, 16'h0, 1'b1, 1'b0, 9'h0, 1'b0);
    end

    // 2: three wait states
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0, 9'h0, 1'b0);
      chk("t2_addr", 32'(mem_addr), 32'd0);
    end
    tick(1'b1, 16'hA5A5, 1'b0, 1'b0, 9'h0, 1'b0);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_err", 32'(fetch_err), 32'd0);

    // 3: timeout is terminal
    do_reset();
    idle(14, 1'b0, 1'b0, 1'b0);
    chk("t3_err14", 32'(fetch_err), 32'd0);
    idle(1, 1'b0, 1'b0, 1'b0);
    chk("t3_err15", 32'(fetch_err), 32'd1);
    tick(1'b1, 16'h1, 1'b1, 1'b1, 9'h7, 1'b0);
    idle(3, 1'b1, 1'b1, 1'b0);
    chk("t3_cmd", 32'(mem_cmd), 32'd1);

    // 4: redirect beats mem_ready at pc=5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'h2000 + 16'(i), 1'b1, 1'b0, 9'h0, 1'b0);
      tick(1'b0, 16'h0, 1'b1, 1'b0, 9'h0, 1'b0);
    end
    chk("t4_pc5", 32'(pc_out), 32'd5);
    tick(1'b1, 16'hBEEF, 1'b0, 1'b1, 9'h040, 1'b0);
    chk("t4_ir", 32'(ir_out), 32'h2004);
    chk("t4_addr", 32'(mem_addr), 32'h040);
    tick(1'b1, 16'h3333, 1'b0, 1'b0, 9'h0, 1'b0);
    chk("t4_pc", 32'(pc_out), 32'h041);

    // 5: halt at a boundary, resume at saved pc
    tick(1'b0, 16'h0, 1'b1, 1'b0, 9'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 16'h0, 1'b1, 1'b0, 9'h0, 1'b1);
      chk("t5_cmd", 32'(mem_cmd), 32'd1);
    end
    tick(1'b0, 16'h0, 1'b0, 1'b0, 9'h0, 1'b0);
    chk("t5_resume", 32'(mem_addr), 32'h041);

    // 6: pc wrap, then reset while waiting
    tick(1'b0, 16'h0, 1'b0, 1'b1, 9'h1FF, 1'b0);
    tick(1'b1, 16'h4444, 1'b1, 1'b0, 9'h0, 1'b0);
    chk("t6_wrap", 32'(pc_out), 32'd0);
    tick(1'b0, 16'h0, 1'b1, 1'b0, 9'h0, 1'b0);
    idle(2, 1'b0, 1'b0, 1'b0);
    do_reset();

    // random traffic in epochs of differing memory speed
    for (int e = 0; e < 30; e++) begin
      rp = (e % 3 == 0) ? 90 : (e % 3 == 1) ? 50 : 4;
      lp = 20 + 30 * (e % 4);
      for (int i = 0; i < 80; i++) begin
        tick($urandom_range(99) < rp, 16'($urandom),
             $urandom_range(99) < lp, $urandom_range(99) < 8,
             9'($urandom), $urandom_range(99) < 25);
      end
      if (e % 5 == 4) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
